// File: rtl/alu_writeback.sv
// alu_writeback: two-entry write-back queue with strobe (ACC/HEAD) and req/ack (STACK/CACHE) delivery.
// Define WB_FORWARD_EN to drive fwd_valid/fwd_data from the youngest matching pending entry.
module alu_writeback (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       wb_valid,
    output logic       wb_ready,
    input  logic [1:0] wb_dest,
    input  logic [7:0] wb_data,
    output logic       acc_we,
    output logic [7:0] acc_wdata,
    output logic       head_we,
    output logic [7:0] head_wdata,
    output logic       stack_req,
    output logic [7:0] stack_wdata,
    input  logic       stack_ack,
    output logic       cache_req,
    output logic [7:0] cache_wdata,
    input  logic       cache_ack,
    input  logic [1:0] hazard_src,
    output logic       hazard,
    output logic       busy,
    output logic       fwd_valid,
    output logic [7:0] fwd_data
);
    localparam logic [1:0] ACC = 2'd0, STACK = 2'd1, HEAD = 2'd2, CACHE = 2'd3;
    typedef enum logic [1:0] {IDLE, STROBE, REQ} state_t;
    state_t     state_q, state_d;
    logic [1:0] count_q, count_d;
    logic [1:0] qdest_q [2];
    logic [1:0] qdest_d [2];
    logic [7:0] qdata_q [2];
    logic [7:0] qdata_d [2];
    logic [1:0] fdest_q, fdest_d;
    logic [7:0] fdata_q, fdata_d;
    logic       wb_ready_q, wb_ready_d;
    logic [3:0] we_q, we_d;
    logic [7:0] wdata_q [4];
    logic [7:0] wdata_d [4];
    logic       accept, have_q, ack_hit, dispatch, pop, push, widx;
    logic [1:0] nxt_dest;
    logic [7:0] nxt_data;
    logic       hit0, hit1, hitf;

    // The in-flight entry lives outside the queue; an empty queue lets an accepted result bypass straight in.
    always_comb begin
        accept   = wb_valid && wb_ready_q;
        have_q   = count_q != 2'd0;
        nxt_dest = have_q ? qdest_q[0] : wb_dest;
        nxt_data = have_q ? qdata_q[0] : wb_data;
        ack_hit  = (fdest_q == STACK) ? stack_ack : cache_ack;
        dispatch = (state_q != REQ) && (have_q || accept);
        pop      = dispatch && have_q;
        push     = accept && (have_q || state_q == REQ);
        widx     = count_q[0] ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        qdest_d  = qdest_q;
        qdata_d  = qdata_q;
        if (pop) begin
            qdest_d[0] = qdest_q[1];
            qdata_d[0] = qdata_q[1];
        end
        if (push) begin
            qdest_d[widx] = wb_dest;
            qdata_d[widx] = wb_data;
        end
        state_d    = dispatch ? (nxt_dest[0] ? REQ : STROBE) : (state_q == REQ && !ack_hit) ? REQ : IDLE;
        fdest_d    = dispatch ? nxt_dest : fdest_q;
        fdata_d    = dispatch ? nxt_data : fdata_q;
        wb_ready_d = count_d != 2'd2;
        for (int d = 0; d < 4; d++) begin
            we_d[d]    = (state_d != IDLE) && (fdest_d == d[1:0]);
            wdata_d[d] = we_d[d] ? fdata_d : 8'h00;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= 2'd0;
            fdest_q    <= 2'd0;
            fdata_q    <= 8'h00;
            wb_ready_q <= 1'b0;
            we_q       <= 4'h0;
            wdata_q    <= '{default: 8'h00};
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            qdest_q    <= qdest_d;
            qdata_q    <= qdata_d;
            fdest_q    <= fdest_d;
            fdata_q    <= fdata_d;
            wb_ready_q <= wb_ready_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
        end
    end

    assign wb_ready    = wb_ready_q;
    assign acc_we      = we_q[ACC];
    assign acc_wdata   = wdata_q[ACC];
    assign head_we     = we_q[HEAD];
    assign head_wdata  = wdata_q[HEAD];
    assign stack_req   = we_q[STACK];
    assign stack_wdata = wdata_q[STACK];
    assign cache_req   = we_q[CACHE];
    assign cache_wdata = wdata_q[CACHE];
    assign hit0        = (count_q != 2'd0) && (qdest_q[0] == hazard_src);
    assign hit1        = (count_q == 2'd2) && (qdest_q[1] == hazard_src);
    assign hitf        = (state_q != IDLE) && (fdest_q == hazard_src);
    assign hazard      = hit0 || hit1 || hitf;
    assign busy        = (count_q != 2'd0) || (state_q != IDLE);
`ifdef WB_FORWARD_EN
    assign fwd_valid = hazard;
    assign fwd_data  = hit1 ? qdata_q[1] : hit0 ? qdata_q[0] : hitf ? fdata_q : 8'h00;
`else
    assign fwd_valid = 1'b0;
    assign fwd_data  = 8'h00;
`endif
endmodule
